// File: rtl/traffic_controller.sv
`default_nettype none
// ============================================================================
// Module   : traffic_controller
// Brief    : Multi-phase GREEN -> YELLOW -> ALL_RED signal controller with an
//            internal tick-driven countdown. Define PED_REQ_EN to enable the
//            pedestrian green-cut feature.
// Revision : 1.0
// ============================================================================
module traffic_controller #(
    parameter int NUM_PHASES    = 2,
    parameter int TIMER_W       = 7,
    parameter int GREEN_TIME    = 105,
    parameter int YELLOW_TIME   = 15,
    parameter int ALL_RED_TIME  = 2,
    parameter int PED_GREEN_CUT = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          tick,
    input  logic                          ped_req,
    output logic [NUM_PHASES-1:0]         green,
    output logic [NUM_PHASES-1:0]         yellow,
    output logic [NUM_PHASES-1:0]         red,
    output logic [$clog2(NUM_PHASES)-1:0] phase,
    output logic [TIMER_W-1:0]            remaining,
    output logic                          phase_start
);

    localparam int PHASE_W = $clog2(NUM_PHASES);

    localparam logic [PHASE_W-1:0] c_last_phase   = PHASE_W'(NUM_PHASES - 1);
    localparam logic [TIMER_W-1:0] c_green_time   = TIMER_W'(GREEN_TIME);
    localparam logic [TIMER_W-1:0] c_yellow_time  = TIMER_W'(YELLOW_TIME);
    localparam logic [TIMER_W-1:0] c_all_red_time = TIMER_W'(ALL_RED_TIME);
    localparam logic [TIMER_W-1:0] c_ped_cut      = TIMER_W'(PED_GREEN_CUT);
    localparam logic [TIMER_W-1:0] c_one          = TIMER_W'(1);

    typedef enum logic [1:0] {
        S_DISABLED = 2'd0,
        S_ALL_RED  = 2'd1,
        S_GREEN    = 2'd2,
        S_YELLOW   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [PHASE_W-1:0]     phase_q, phase_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [TIMER_W-1:0]     w_timer_next;
    logic [NUM_PHASES-1:0]  green_q, green_d;
    logic [NUM_PHASES-1:0]  yellow_q, yellow_d;
    logic [NUM_PHASES-1:0]  red_q, red_d;
    logic                   phase_start_q, phase_start_d;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        w_timer_next = timer_q;
        if (!enable) begin
            state_d      = S_DISABLED;
            phase_d      = c_last_phase;
            w_timer_next = '0;
        end else if (state_q == S_DISABLED) begin
            state_d      = S_ALL_RED;
            w_timer_next = c_all_red_time;
        end else if (tick) begin
            if (timer_q > c_one) begin
                w_timer_next = timer_q - c_one;
            end else begin
                case (state_q)
                    S_ALL_RED: begin
                        state_d      = S_GREEN;
                        phase_d      = (phase_q == c_last_phase) ? '0 : phase_q + 1'b1;
                        w_timer_next = c_green_time;
                    end
                    S_GREEN: begin
                        state_d      = S_YELLOW;
                        w_timer_next = c_yellow_time;
                    end
                    S_YELLOW: begin
                        state_d      = S_ALL_RED;
                        w_timer_next = c_all_red_time;
                    end
                    default: begin
                        state_d      = S_DISABLED;
                        w_timer_next = '0;
                    end
                endcase
            end
        end
    end

`ifdef PED_REQ_EN
    logic ped_pend_q, ped_pend_d;
    logic w_ped_pend;

    assign w_ped_pend = ped_pend_q | ped_req;

    always_comb begin
        ped_pend_d = w_ped_pend;
        timer_d    = w_timer_next;
        if (!enable) begin
            ped_pend_d = 1'b0;
        end else begin
            if (state_q == S_GREEN && state_d == S_YELLOW) begin
                ped_pend_d = 1'b0;
            end
            // The cut overrides any decrement taken on the same clock.
            if (state_q == S_GREEN && w_ped_pend && timer_q > c_ped_cut) begin
                timer_d = c_ped_cut;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pend_q <= 1'b0;
        end else begin
            ped_pend_q <= ped_pend_d;
        end
    end
`else
    logic w_unused_ped;
    assign w_unused_ped = ped_req ^ (|c_ped_cut);
    assign timer_d      = w_timer_next;
`endif

    // Lamps are decoded from next-state so the registered copies line up with state.
    always_comb begin
        green_d  = '0;
        yellow_d = '0;
        if (state_d == S_GREEN) begin
            green_d[phase_d] = 1'b1;
        end
        if (state_d == S_YELLOW) begin
            yellow_d[phase_d] = 1'b1;
        end
        red_d         = ~(green_d | yellow_d);
        phase_start_d = (state_d == S_GREEN) && (state_q != S_GREEN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_DISABLED;
            phase_q       <= c_last_phase;
            timer_q       <= '0;
            green_q       <= '0;
            yellow_q      <= '0;
            red_q         <= '1;
            phase_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            timer_q       <= timer_d;
            green_q       <= green_d;
            yellow_q      <= yellow_d;
            red_q         <= red_d;
            phase_start_q <= phase_start_d;
        end
    end

    assign green       = green_q;
    assign yellow      = yellow_q;
    assign red         = red_q;
    assign phase       = phase_q;
    assign remaining   = timer_q;
    assign phase_start = phase_start_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_controller
// Brief    : Scoreboard bench for traffic_controller with a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_traffic_controller;

    localparam int NP = 2, GT = 5, YT = 2, AT = 1, CUT = 2;
    localparam int S_DIS = 0, S_AR = 1, S_G = 2, S_Y = 3;
`ifdef PED_REQ_EN
    localparam int PED_REM = 2, PED_WAIT = 2;
`else
    localparam int PED_REM = 4, PED_WAIT = 4;
`endif

    logic       clk, rst_n, enable, tick, ped_req;
    logic [1:0] green, yellow, red;
    logic       phase;
    logic [6:0] remaining;
    logic       phase_start;

    typedef struct packed {
        logic [1:0] g;
        logic [1:0] y;
        logic [1:0] r;
        logic       p;
        logic [6:0] rem;
        logic       ps;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    int m_state, m_phase, m_timer;
    bit m_ped, m_ps;

    traffic_controller #(
        .NUM_PHASES(NP), .TIMER_W(7), .GREEN_TIME(GT), .YELLOW_TIME(YT),
        .ALL_RED_TIME(AT), .PED_GREEN_CUT(CUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tick(tick), .ped_req(ped_req),
        .green(green), .yellow(yellow), .red(red), .phase(phase),
        .remaining(remaining), .phase_start(phase_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = S_DIS; m_phase = NP - 1; m_timer = 0; m_ped = 1'b0; m_ps = 1'b0;
    endtask

    task automatic model_update(input bit en, input bit tk, input bit pr);
        int ns = m_state, np = m_phase, nt = m_timer;
        bit nped = m_ped;
        if (!en) begin
            ns = S_DIS; nt = 0; np = NP - 1; nped = 1'b0;
        end else begin
            if (m_state == S_DIS) begin
                ns = S_AR; nt = AT;
            end else if (tk && m_timer > 1) begin
                nt = m_timer - 1;
            end else if (tk) begin
                case (m_state)
                    S_AR:    begin ns = S_G;  np = (m_phase + 1) % NP; nt = GT; end
                    S_G:     begin ns = S_Y;  nt = YT; end
                    default: begin ns = S_AR; nt = AT; end
                endcase
            end
`ifdef PED_REQ_EN
            begin
                bit pend;
                pend = m_ped | pr;
                nped = pend;
                if (m_state == S_G && pend && m_timer > CUT) nt = CUT;
                if (m_state == S_G && ns == S_Y) nped = 1'b0;
            end
`endif
        end
        m_ps    = (ns == S_G) && (m_state != S_G);
        m_state = ns; m_phase = np; m_timer = nt; m_ped = nped;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.g = '0;
        e.y = '0;
        if (m_state == S_G) e.g[m_phase] = 1'b1;
        if (m_state == S_Y) e.y[m_phase] = 1'b1;
        e.r   = ~(e.g | e.y);
        e.p   = 1'(m_phase);
        e.rem = 7'(m_timer);
        e.ps  = m_ps;
        return e;
    endfunction

    // Drive one clock of stimulus; the model's prediction is queued at the edge.
    task automatic step(input bit en, input bit tk, input bit pr);
        enable = en; tick = tk; ped_req = pr;
        if (!rst_n) model_reset();
        else        model_update(en, tk, pr);
        @(posedge clk);
        sb.push_back(model_out());
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            if ({green, yellow, red, phase, remaining, phase_start} !== e) begin
                failed++;
                $display("FAIL scoreboard t=%0t got g=%b y=%b r=%b ph=%0d rem=%0d ps=%b exp g=%b y=%b r=%b ph=%0d rem=%0d ps=%b",
                         $time, green, yellow, red, phase, remaining, phase_start,
                         e.g, e.y, e.r, e.p, e.rem, e.ps);
            end
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
        tests++;
        if ({red, green, yellow, remaining, phase} !== {2'b11, 2'b00, 2'b00, 7'd0, 1'b1}) begin
            failed++;
            $display("FAIL reset_hold got r=%b g=%b y=%b rem=%0d ph=%0d exp r=11 g=00 y=00 rem=0 ph=1",
                     red, green, yellow, remaining, phase);
        end
    endtask

    task automatic test_enable_sequence();
        step(1'b1, 1'b1, 1'b0);
        tests++;
        if ({red, remaining, phase_start} !== {2'b11, 7'd1, 1'b0}) begin
            failed++;
            $display("FAIL all_red_entry got r=%b rem=%0d ps=%b exp r=11 rem=1 ps=0", red, remaining, phase_start);
        end
        step(1'b1, 1'b1, 1'b0);
        tests++;
        if ({green, phase, remaining, phase_start} !== {2'b01, 1'b0, 7'd5, 1'b1}) begin
            failed++;
            $display("FAIL first_green got g=%b ph=%0d rem=%0d ps=%b exp g=01 ph=0 rem=5 ps=1",
                     green, phase, remaining, phase_start);
        end
        for (int k = 4; k >= 1; k--) begin
            step(1'b1, 1'b1, 1'b0);
            tests++;
            if ({green, remaining, phase_start} !== {2'b01, 7'(k), 1'b0}) begin
                failed++;
                $display("FAIL green_count got g=%b rem=%0d ps=%b exp g=01 rem=%0d ps=0", green, remaining, phase_start, k);
            end
        end
        for (int k = 2; k >= 1; k--) begin
            step(1'b1, 1'b1, 1'b0);
            tests++;
            if ({yellow, green, remaining} !== {2'b01, 2'b00, 7'(k)}) begin
                failed++;
                $display("FAIL yellow got y=%b g=%b rem=%0d exp y=01 g=00 rem=%0d", yellow, green, remaining, k);
            end
        end
        step(1'b1, 1'b1, 1'b0);
        tests++;
        if ({red, remaining} !== {2'b11, 7'd1}) begin
            failed++;
            $display("FAIL clearance got r=%b rem=%0d exp r=11 rem=1", red, remaining);
        end
        step(1'b1, 1'b1, 1'b0);
        tests++;
        if ({green, phase, phase_start} !== {2'b10, 1'b1, 1'b1}) begin
            failed++;
            $display("FAIL second_green got g=%b ph=%0d ps=%b exp g=10 ph=1 ps=1", green, phase, phase_start);
        end
    endtask

    task automatic test_rotation();
        int pulses = 0;
        for (int i = 1; i <= 18; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (phase_start) pulses++;
            if (i == 8) begin
                tests++;
                if ({green, phase, phase_start} !== {2'b01, 1'b0, 1'b1}) begin
                    failed++;
                    $display("FAIL phase_wrap got g=%b ph=%0d ps=%b exp g=01 ph=0 ps=1", green, phase, phase_start);
                end
            end
        end
        tests++;
        if (pulses != 2) begin
            failed++;
            $display("FAIL pulse_count got %0d exp 2", pulses);
        end
    endtask

    task automatic test_tick_hold();
        int n = 0;
        logic [1:0] g0;
        while (!(green != 2'b00 && remaining == 7'd3) && n < 40) begin
            step(1'b1, 1'b1, 1'b0);
            n++;
        end
        tests++;
        if (n >= 40) begin
            failed++;
            $display("FAIL hold_search got timeout exp green rem=3");
        end
        g0 = green;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0);
            tests++;
            if ({green, remaining} !== {g0, 7'd3}) begin
                failed++;
                $display("FAIL tick_hold got g=%b rem=%0d exp g=%b rem=3", green, remaining, g0);
            end
        end
    endtask

    task automatic test_disable_mid_green();
        int n = 0;
        while (!(green != 2'b00 && remaining == 7'd4) && n < 40) begin
            step(1'b1, 1'b1, 1'b0);
            n++;
        end
        step(1'b0, 1'b1, 1'b0);
        tests++;
        if ({red, yellow, remaining, phase} !== {2'b11, 2'b00, 7'd0, 1'b1}) begin
            failed++;
            $display("FAIL abort got r=%b y=%b rem=%0d ph=%0d exp r=11 y=00 rem=0 ph=1", red, yellow, remaining, phase);
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        tests++;
        if ({green, phase, phase_start, remaining} !== {2'b01, 1'b0, 1'b1, 7'd5}) begin
            failed++;
            $display("FAIL restart got g=%b ph=%0d ps=%b rem=%0d exp g=01 ph=0 ps=1 rem=5",
                     green, phase, phase_start, remaining);
        end
    endtask

    task automatic test_ped_cut();
        int n = 0;
        step(1'b1, 1'b1, 1'b1);
        tests++;
        if (remaining !== 7'(PED_REM)) begin
            failed++;
            $display("FAIL ped_cut got rem=%0d exp rem=%0d", remaining, PED_REM);
        end
        while (yellow == 2'b00 && n < 10) begin
            step(1'b1, 1'b1, 1'b0);
            n++;
        end
        tests++;
        if (n != PED_WAIT) begin
            failed++;
            $display("FAIL ped_green_len got %0d exp %0d", n, PED_WAIT);
        end
    endtask

    task automatic test_ped_pending();
        int n = 0;
        step(1'b1, 1'b1, 1'b1);
        while (!phase_start && n < 10) begin
            step(1'b1, 1'b1, 1'b0);
            n++;
        end
        step(1'b1, 1'b1, 1'b0);
        tests++;
        if ({green, remaining} !== {2'b10, 7'(PED_REM)}) begin
            failed++;
            $display("FAIL ped_pending got g=%b rem=%0d exp g=10 rem=%0d", green, remaining, PED_REM);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({red, green, yellow, remaining, phase, phase_start} !== {2'b11, 2'b00, 2'b00, 7'd0, 1'b1, 1'b0}) begin
            failed++;
            $display("FAIL async_reset got r=%b g=%b y=%b rem=%0d ph=%0d ps=%b exp r=11 g=00 y=00 rem=0 ph=1 ps=0",
                     red, green, yellow, remaining, phase, phase_start);
        end
        step(1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        tests++;
        if ({red, remaining} !== {2'b11, 7'd1}) begin
            failed++;
            $display("FAIL post_reset got r=%b rem=%0d exp r=11 rem=1", red, remaining);
        end
        step(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; tick = 1'b0; ped_req = 1'b0;
        model_reset();
        test_reset();
        test_enable_sequence();
        test_rotation();
        test_tick_hold();
        test_disable_mid_green();
        test_ped_cut();
        test_ped_pending();
        test_async_reset();
        @(negedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain got %0d left exp 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/traffic_controller.md
# traffic_controller

Parametrised multi-phase traffic signal controller with its own countdown timer. It drives NUM_PHASES signal heads through a GREEN -> YELLOW -> ALL_RED rotation, advancing on an external 1 Hz tick strobe. Optionally, a pedestrian request shortens the current green. It sits between the system tick generator and the lamp drivers, and supersedes the single-head light that decoded an externally supplied master timer.

## Interface
- NUM_PHASES, 2: number of conflicting phases (signal heads), >= 2
- TIMER_W, 7: countdown width; every duration must be <= 2^TIMER_W - 1
- GREEN_TIME, 105: green duration in ticks, >= 1
- YELLOW_TIME, 15: yellow duration in ticks, >= 1
- ALL_RED_TIME, 2: all-red clearance in ticks, >= 1
- PED_GREEN_CUT, 10: remaining-green value applied on pedestrian request, 1 <= value < GREEN_TIME
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  run when high; low forces DISABLED (all red)
- tick  in  1  one-cycle timing strobe, sampled on clk
- ped_req  in  1  pedestrian request pulse (ignored unless PED_REQ_EN)
- green  out  NUM_PHASES  per-phase green lamp
- yellow  out  NUM_PHASES  per-phase yellow lamp
- red  out  NUM_PHASES  per-phase red lamp
- phase  out  $clog2(NUM_PHASES)  index of the phase owning green/yellow
- remaining  out  TIMER_W  ticks left in current state (0 in DISABLED)
- phase_start  out  1  one-cycle pulse on the clock that enters GREEN

## Operation
- States: DISABLED, ALL_RED, GREEN, YELLOW; state, phase, and timer are registered.
- Lamp decode:
  - Exactly one of green[i]/yellow[i]/red[i] is high for every i at all times.
  - In GREEN, green[phase] is high; in YELLOW, yellow[phase] is high.
  - All other heads, and all heads in DISABLED/ALL_RED, show red.
- Transitions:
  - DISABLED -> ALL_RED when enable=1, loading ALL_RED_TIME.
  - ALL_RED -> GREEN: phase <= (phase+1) mod NUM_PHASES; loads GREEN_TIME; asserts phase_start.
  - GREEN -> YELLOW: loads YELLOW_TIME, phase unchanged.
  - YELLOW -> ALL_RED: loads ALL_RED_TIME.
- Countdown: on tick, if timer > 1, decrement; else take the transition and load the next duration. Each state lasts exactly its duration in ticks.
- enable=0 takes priority over everything: next clock goes to DISABLED, timer 0, phase NUM_PHASES-1, ped latch cleared. Mid-green abort is allowed, with no yellow.
- Phase wrap: phase NUM_PHASES-1 advances to 0. The first GREEN after enable is therefore phase 0.
- With no tick, state and timer hold indefinitely.

## Timing
- Reset (async assert) values:
  - state DISABLED, phase NUM_PHASES-1, remaining 0
  - green=0, yellow=0, red=all ones
  - phase_start=0, ped latch 0
- Lamps, phase, and remaining decode from registers and change one clock after the causing tick/enable edge.
- phase_start is high for the single cycle in which the GREEN state is first visible.
- Reset deassertion: the first transition occurs on the first clock edge with rst_n=1 and enable=1.

## Configuration
- PED_REQ_EN defined:
  - ped_req sets a pending latch.
  - While in GREEN with the latch set and timer > PED_GREEN_CUT, the next clock loads timer with PED_GREEN_CUT. This cut wins over a simultaneous tick decrement.
  - The latch clears on GREEN -> YELLOW or on enable=0.
  - A request arriving in YELLOW/ALL_RED stays pending for the next green.
- PED_REQ_EN undefined: ped_req port exists but is ignored; no latch logic is synthesised.

## Test plan
All cases use NUM_PHASES=2, GREEN_TIME=5, YELLOW_TIME=2, ALL_RED_TIME=1, PED_GREEN_CUT=2, and tick high every cycle unless stated.

- Reset with enable=0 -> red=2'b11, green=yellow=0, remaining=0, phase=1, held for 20 cycles.
- Raise enable -> ALL_RED 1 cycle, then phase_start pulse with phase=0 and green=2'b01 for 5 cycles (remaining 5..1), yellow=2'b01 for 2, all-red 1, then green=2'b10 with phase=1.
- Full rotation -> after phase 1 yellow/all-red, phase wraps to 0 and phase_start pulses once per green.
- Tick held low for 10 cycles mid-green at remaining=3 -> remaining stays 3 and lamps stay unchanged.
- Drop enable at green remaining=4 -> next clock all red, remaining 0, no yellow; re-enable -> restart at ALL_RED then phase 0.
- PED_REQ_EN defined: pulse ped_req at green remaining=5 -> next clock remaining=2, yellow two ticks later. Undefined: same stimulus -> green lasts the full 5 ticks.
